// File: rtl/qbert_pkg.sv
// Shared Q*bert game types and constants.
// Used by the cube colour controller and its bus interface.
package qbert_pkg;

  localparam int N_CUBE_C = 28;

  localparam logic RULE_SET    = 1'b0;
  localparam logic RULE_TOGGLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    WAIT_LAND = 3'd2,
    UPDATE    = 3'd3,
    FLASH     = 3'd4,
    DONE      = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/cube_color_ctrl_if.sv
// NIOS / map-block side bundle of the cube colour controller.
// master drives the game events, slave is the controller.
interface cube_color_ctrl_if
  import qbert_pkg::*;
#(
  parameter int N = N_CUBE_C
) ();

  logic         e_start_lvl;
  logic         e_rule;
  logic         e_pause_qb;
  logic         done_move;
  logic [N-1:0] position_qb;
  logic [N-1:0] color_state;
  logic [4:0]   n_colored;
  logic         score_pulse;
  logic         off_map;
  logic         level_done;
  logic [2:0]   ctrl_state;

  modport master (
    output e_start_lvl,
    output e_rule,
    output e_pause_qb,
    output done_move,
    output position_qb,
    input  color_state,
    input  n_colored,
    input  score_pulse,
    input  off_map,
    input  level_done,
    input  ctrl_state
  );

  modport slave (
    input  e_start_lvl,
    input  e_rule,
    input  e_pause_qb,
    input  done_move,
    input  position_qb,
    output color_state,
    output n_colored,
    output score_pulse,
    output off_map,
    output level_done,
    output ctrl_state
  );

endinterface

// File: rtl/lowest_one_sel.sv
// N-bit priority encoder: one-hot mask of the lowest set bit.
// valid is low when no bit is set.
module lowest_one_sel #(
  parameter int N = 28
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] mask,
  output logic         valid
);

  // x & -x isolates the lowest set bit
  assign mask  = vec & (~vec + {{(N-1){1'b0}}, 1'b1});
  assign valid = |vec;

endmodule

// File: rtl/cube_color_ctrl.sv
// Q*bert pyramid colour-rule controller: landings, level
// completion flash and level_done towards the NIOS.
module cube_color_ctrl
  import qbert_pkg::*;
#(
  parameter int          N_CUBE       = N_CUBE_C,
  parameter int          LAND_DELAY   = 2,
  parameter logic [31:0] FLASH_PERIOD = 32'd3_300_000,
  parameter int          FLASH_COUNT  = 6
) (
  input  logic            CLK_33,
  input  logic            reset,
  cube_color_ctrl_if.slave bus
);

  localparam int DW =
    (LAND_DELAY < 2) ? 1 : $clog2(LAND_DELAY + 1);
  localparam int HW =
    (FLASH_COUNT < 2) ? 1 : $clog2(FLASH_COUNT + 1);

  localparam logic [N_CUBE-1:0] ONES = '1;
  localparam logic [4:0] N_FULL = 5'(N_CUBE);
  localparam logic [DW-1:0] DLY = DW'(LAND_DELAY);
  localparam logic [HW-1:0] HLAST = HW'(FLASH_COUNT);
  localparam logic [31:0] FP_LAST = FLASH_PERIOD - 32'd1;

  ctrl_state_t       state;
  logic [DW-1:0]     dly_cnt;
  logic [31:0]       fl_cnt;
  logic [HW-1:0]     half_cnt;
  logic [N_CUBE-1:0] pos_q;
  logic [N_CUBE-1:0] color_q;
  logic [4:0]        n_q;
  logic              score_q;
  logic              off_q;
  logic              done_q;

  logic [N_CUBE-1:0] sel_mask;
  logic              sel_valid;
  logic [N_CUBE-1:0] upd_color;
  logic [4:0]        upd_n;
  logic              old_bit;
  logic              rise;

  lowest_one_sel #(
    .N (N_CUBE)
  ) u_sel (
    .vec   (pos_q),
    .mask  (sel_mask),
    .valid (sel_valid)
  );

  always_comb begin
    old_bit   = |(color_q & sel_mask);
    upd_color = color_q;
    upd_n     = n_q;
    rise      = 1'b0;
    if (sel_valid) begin
      rise = !old_bit;
      if (bus.e_rule == RULE_TOGGLE)
        upd_color = color_q ^ sel_mask;
      else
        upd_color = color_q | sel_mask;
      // count tracks each bit edge, never a recount
      if (rise)
        upd_n = n_q + 5'd1;
      else if (bus.e_rule == RULE_TOGGLE)
        upd_n = n_q - 5'd1;
    end
  end

  always_ff @(posedge CLK_33) begin
    if (reset) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      fl_cnt   <= '0;
      half_cnt <= '0;
      pos_q    <= '0;
      color_q  <= '0;
      n_q      <= '0;
      score_q  <= 1'b0;
      off_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      score_q <= 1'b0;
      off_q   <= 1'b0;
      done_q  <= 1'b0;
      if (bus.e_start_lvl) begin
        state    <= PLAY;
        color_q  <= '0;
        n_q      <= '0;
        dly_cnt  <= '0;
        fl_cnt   <= '0;
        half_cnt <= '0;
      end else if (!bus.e_pause_qb) begin
        unique case (state)
          IDLE: ;
          PLAY: begin
            if (bus.done_move) begin
              dly_cnt <= DLY;
              state   <= WAIT_LAND;
            end
          end
          WAIT_LAND: begin
            if (dly_cnt == '0) begin
              pos_q <= bus.position_qb;
              state <= UPDATE;
            end else begin
              dly_cnt <= dly_cnt - DW'(1);
            end
          end
          UPDATE: begin
            color_q <= upd_color;
            n_q     <= upd_n;
            score_q <= rise;
            off_q   <= !sel_valid;
            if (upd_n == N_FULL) begin
              state    <= FLASH;
              fl_cnt   <= '0;
              half_cnt <= '0;
            end else begin
              state <= PLAY;
            end
          end
          FLASH: begin
            // phase changes on the first cycle of each period
            if (fl_cnt == '0) begin
              if (half_cnt == HLAST) begin
                color_q <= ONES;
                n_q     <= N_FULL;
                state   <= DONE;
              end else begin
                color_q  <= half_cnt[0] ? ONES : '0;
                n_q      <= half_cnt[0] ? N_FULL : 5'd0;
                half_cnt <= half_cnt + HW'(1);
              end
            end
            fl_cnt <= (fl_cnt == FP_LAST) ?
                      32'd0 : fl_cnt + 32'd1;
          end
          DONE: begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.color_state = color_q;
  assign bus.n_colored   = n_q;
  assign bus.score_pulse = score_q;
  assign bus.off_map     = off_q;
  assign bus.level_done  = done_q;
  assign bus.ctrl_state  = state;

endmodule

// File: tb/tb_cube_color_ctrl.sv
// Directed bench for cube_color_ctrl: landing table plus
// flash, pause, restart and reset sequences.
module tb_cube_color_ctrl;
  import qbert_pkg::*;

  localparam int FP = 4;
  localparam int FC = 6;
  localparam logic [27:0] ALL1 = 28'hFFF_FFFF;

  logic CLK_33 = 1'b0;
  logic reset  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  logic [27:0] cur_color;

  cube_color_ctrl_if #(.N(28)) bus ();

  cube_color_ctrl #(
    .FLASH_PERIOD (32'(FP)),
    .FLASH_COUNT  (FC)
  ) dut (
    .CLK_33 (CLK_33),
    .reset  (reset),
    .bus    (bus)
  );

  always #15 CLK_33 = ~CLK_33;

  typedef struct {
    logic        start;
    logic        rule;
    logic [27:0] pos;
    logic [27:0] exp_c;
    logic [4:0]  exp_n;
    logic        exp_s;
    logic        exp_o;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // every cycle also checks the count/popcount invariant
  task automatic tick();
    @(posedge CLK_33);
    #1;
    chk("popcount", 32'(bus.n_colored),
        32'($countones(bus.color_state)));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_lvl();
    bus.e_start_lvl = 1'b1;
    tick();
    bus.e_start_lvl = 1'b0;
    cur_color = '0;
  endtask

  task automatic land(input logic [27:0] pos,
                      input logic [27:0] exp_c,
                      input logic [4:0]  exp_n,
                      input logic        exp_s,
                      input logic        exp_o,
                      input logic [2:0]  exp_st);
    bus.position_qb = pos;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move   = 1'b0;
    ticks(3);
    chk("lat_hold", bus.color_state, cur_color);
    chk("pre_pulse", {bus.score_pulse, bus.off_map}, 0);
    tick();
    chk("color", bus.color_state, exp_c);
    chk("n_col", bus.n_colored, exp_n);
    chk("score", bus.score_pulse, exp_s);
    chk("offmap", bus.off_map, exp_o);
    chk("state", bus.ctrl_state, exp_st);
    cur_color = exp_c;
  endtask

  task automatic fill();
    logic [27:0] one;
    logic [27:0] e;
    one = 28'h1;
    start_lvl();
    bus.e_rule = RULE_SET;
    for (int i = 0; i < 28; i++) begin
      e = (one << (i + 1)) - one;
      land(one << i, e, 5'(i + 1), 1'b1, 1'b0,
           (i == 27) ? FLASH : PLAY);
      if (i < 27) tick();
    end
  endtask

  task automatic idle_ignore(input logic [27:0] exp_c);
    bus.position_qb = 28'h10;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move   = 1'b0;
    ticks(6);
    chk("idle_state", bus.ctrl_state, IDLE);
    chk("idle_color", bus.color_state, exp_c);
  endtask

  initial begin
    logic [27:0] fexp;
    logic [27:0] fprev;
    int tog;

    vt[0] = '{1, 0, 28'h1, 28'h1, 1, 1, 0};
    vt[1] = '{0, 0, 28'h1, 28'h1, 1, 0, 0};
    vt[2] = '{1, 1, 28'h20, 28'h20, 1, 1, 0};
    vt[3] = '{0, 1, 28'h20, 28'h0, 0, 0, 0};
    vt[4] = '{0, 1, 28'h0, 28'h0, 0, 0, 1};
    vt[5] = '{0, 1, 28'hC, 28'h4, 1, 1, 0};
    vt[6] = '{0, 0, 28'h800_0000, 28'h800_0004, 2, 1, 0};
    vt[7] = '{0, 0, 28'hFFF_FFF0, 28'h800_0014, 3, 1, 0};
    vt[8] = '{0, 1, 28'h4, 28'h800_0010, 2, 0, 0};
    vt[9] = '{0, 0, 28'h0, 28'h800_0010, 2, 0, 1};

    bus.e_start_lvl = 1'b0;
    bus.e_rule      = 1'b0;
    bus.e_pause_qb  = 1'b0;
    bus.done_move   = 1'b0;
    bus.position_qb = '0;
    cur_color       = '0;

    ticks(3);
    reset = 1'b0;
    tick();
    chk("rst_color", bus.color_state, 0);
    chk("rst_n", bus.n_colored, 0);
    chk("rst_state", bus.ctrl_state, IDLE);
    chk("rst_pulses", {bus.score_pulse, bus.off_map,
                       bus.level_done}, 0);
    idle_ignore(28'h0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].start) start_lvl();
      bus.e_rule = vt[i].rule;
      land(vt[i].pos, vt[i].exp_c, vt[i].exp_n,
           vt[i].exp_s, vt[i].exp_o, PLAY);
      tick();
      chk("pulse_1cyc", {bus.score_pulse, bus.off_map}, 0);
    end

    fill();
    fprev = ALL1;
    tog = 0;
    for (int k = 1; k <= FP * FC; k++) begin
      tick();
      fexp = (((k - 1) / FP) % 2 == 0) ? 28'h0 : ALL1;
      if (fexp != fprev) tog++;
      fprev = fexp;
      chk("flash_color", bus.color_state, fexp);
      chk("flash_state", bus.ctrl_state, FLASH);
      chk("flash_nodone", bus.level_done, 0);
    end
    chk("flash_toggles", tog, FC);
    tick();
    chk("end_color", bus.color_state, ALL1);
    chk("end_state", bus.ctrl_state, DONE);
    chk("end_nodone", bus.level_done, 0);
    tick();
    chk("lvl_done", bus.level_done, 1);
    chk("done_idle", bus.ctrl_state, IDLE);
    chk("done_color", bus.color_state, ALL1);
    chk("done_n", bus.n_colored, 28);
    tick();
    chk("lvl_done_1cyc", bus.level_done, 0);
    idle_ignore(ALL1);

    fill();
    ticks(6);
    start_lvl();
    chk("restart_color", bus.color_state, 0);
    chk("restart_n", bus.n_colored, 0);
    chk("restart_state", bus.ctrl_state, PLAY);
    bus.e_rule = RULE_SET;
    land(28'h1, 28'h1, 1, 1, 0, PLAY);
    tick();

    bus.e_pause_qb  = 1'b1;
    bus.position_qb = 28'h200;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move   = 1'b0;
    tick();
    bus.e_pause_qb  = 1'b0;
    ticks(5);
    chk("drop_state", bus.ctrl_state, PLAY);
    chk("drop_color", bus.color_state, 28'h1);

    bus.position_qb = 28'h8;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move   = 1'b0;
    bus.e_pause_qb  = 1'b1;
    ticks(10);
    chk("pause_state", bus.ctrl_state, WAIT_LAND);
    bus.e_pause_qb  = 1'b0;
    ticks(3);
    chk("pause_upd", bus.ctrl_state, UPDATE);
    chk("pause_hold", bus.color_state, 28'h1);
    tick();
    chk("pause_color", bus.color_state, 28'h9);
    chk("pause_n", bus.n_colored, 2);
    chk("pause_score", bus.score_pulse, 1);

    fill();
    ticks(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_color", bus.color_state, 0);
    chk("mrst_n", bus.n_colored, 0);
    chk("mrst_state", bus.ctrl_state, IDLE);
    chk("mrst_pulses", {bus.score_pulse, bus.off_map,
                        bus.level_done}, 0);
    idle_ignore(28'h0);
    start_lvl();
    chk("mrst_start", bus.ctrl_state, PLAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
